// File: rtl/sm83_bus_seq.sv
// M-cycle bus sequencer: expands one core request into T_PER_M phases with strobes, wait states and a completion pulse.
// Optional macro SM83_BUS_TIMEOUT_EN bounds wait states at MAX_WAIT and reports a timeout on rsp_err.
module sm83_bus_seq #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int T_PER_M  = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              m_start,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [1:0]        dbg_state
);
    localparam int PH_W = $clog2(T_PER_M);
    localparam int WC_W = $clog2(MAX_WAIT + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(T_PER_M - 1);
    localparam logic [PH_W-1:0] PH_SAMP = PH_W'(T_PER_M - 2);
    localparam logic [WC_W-1:0] WC_MAX  = WC_W'(MAX_WAIT);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_WAIT = 2'd2} state_t;

    // Handshake: a request transfers on a rising edge where req_valid & req_ready;
    // req_ready is high in IDLE and in the last phase of an M-cycle, never while stalled.
    state_t            state_q, state_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef SM83_BUS_TIMEOUT_EN
    logic              err_q, err_d;
`endif

    logic is_rd, is_wr, is_rw, accept, strobe;

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        wait_cnt_d = wait_cnt_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
`ifdef SM83_BUS_TIMEOUT_EN
        err_d      = err_q;
`endif
        // op 11 falls through as internal: neither read nor write
        is_rd     = (op_q == 2'b01);
        is_wr     = (op_q == 2'b10);
        is_rw     = is_rd | is_wr;
        req_ready = (state_q == S_IDLE) || ((state_q == S_ACTIVE) && (ph_q == PH_LAST));
        accept    = req_valid & req_ready;
        m_start   = (state_q == S_ACTIVE) && (ph_q == '0);
        rsp_valid = (state_q == S_ACTIVE) && (ph_q == PH_LAST);
        strobe    = ((state_q == S_ACTIVE) && (ph_q != '0) && (ph_q != PH_LAST)) || (state_q == S_WAIT);
        mem_rd    = strobe & is_rd;
        mem_wr    = strobe & is_wr;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ACTIVE;
                    ph_d    = '0;
                end
            end
            S_ACTIVE: begin
                if (ph_q == PH_LAST) begin
                    ph_d    = '0;
                    state_d = accept ? S_ACTIVE : S_IDLE;
                end else if ((ph_q == PH_SAMP) && is_rw && !mem_ready) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                    if ((ph_q == PH_SAMP) && is_rd) begin
                        rdata_d = mem_rdata;
                    end
                end
            end
            S_WAIT: begin
                if (mem_ready) begin
                    state_d    = S_ACTIVE;
                    ph_d       = PH_LAST;
                    wait_cnt_d = '0;
                    if (is_rd) begin
                        rdata_d = mem_rdata;
                    end
                end else begin
                    if (wait_cnt_q != WC_MAX) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
`ifdef SM83_BUS_TIMEOUT_EN
                    // Give up once the count reaches the limit; the bus sees the strobe drop
                    if (wait_cnt_d == WC_MAX) begin
                        state_d    = S_ACTIVE;
                        ph_d       = PH_LAST;
                        wait_cnt_d = '0;
                        err_d      = 1'b1;
                        rdata_d    = {DATA_W{1'b1}};
                    end
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                ph_d    = '0;
            end
        endcase

        if (accept) begin
            op_d    = req_op;
            addr_d  = req_addr;
            wdata_d = req_wdata;
`ifdef SM83_BUS_TIMEOUT_EN
            err_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ph_q       <= '0;
            wait_cnt_q <= '0;
            op_q       <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
`ifdef SM83_BUS_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            wait_cnt_q <= wait_cnt_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
`ifdef SM83_BUS_TIMEOUT_EN
            err_q      <= err_d;
`endif
        end
    end

`ifdef SM83_BUS_TIMEOUT_EN
    assign rsp_err = rsp_valid & err_q;
`else
    assign rsp_err = 1'b0;
`endif
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rsp_rdata = rdata_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_sm83_bus_seq.sv
// Bench for sm83_bus_seq at T_PER_M=4, MAX_WAIT=15: vector table, back-to-back, stall timeout and reset-abort sequences.
module tb_sm83_bus_seq;
    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int TPM = 4;
    localparam int MW  = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd, mem_wr;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b1;
    logic          m_start, rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    dbg_state;

    sm83_bus_seq #(.ADDR_W(AW), .DATA_W(DW), .T_PER_M(TPM), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .m_start(m_start),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW:0] exp_q[$];
    logic [DW:0] exp_e;
    logic [DW-1:0] last_rd = '0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Scoreboard: every completion pulse must match the oldest outstanding {err, rdata}
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp at %0t: got rsp_valid=1 expected none", $time);
            end else begin
                exp_e = exp_q.pop_front();
                chkv("rsp_err_rdata", 32'({rsp_err, rsp_rdata}), 32'(exp_e));
            end
        end
    end

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            nwait;
    } vec_t;

    vec_t vecs[7];

    task automatic run_txn(input vec_t v);
        logic isrd, iswr, rw;
        logic [DW-1:0] wr_seen;
        int nw, lat;
        isrd = (v.op == 2'b01);
        iswr = (v.op == 2'b10);
        rw   = isrd | iswr;
        nw   = rw ? v.nwait : 0;
        lat  = TPM + nw;
        wr_seen = '0;
        @(negedge clk);
        chk1("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_op    = v.op;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        mem_rdata = v.rdata;
        mem_ready = 1'b1;
        @(posedge clk);
        if (isrd) last_rd = v.rdata;
        exp_q.push_back({1'b0, last_rd});
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = 1'b0;
                req_addr  = AW'($urandom_range(0, 65535));
                req_wdata = DW'($urandom_range(0, 255));
            end
            chk1("m_start", m_start, c == 1);
            chk1("mem_rd", mem_rd, isrd && c >= 2 && c <= 3 + nw);
            chk1("mem_wr", mem_wr, iswr && c >= 2 && c <= 3 + nw);
            chk1("rsp_valid_timing", rsp_valid, c == lat);
            chk1("req_ready_busy", req_ready, c == lat);
            if (rw) chkv("mem_addr", 32'(mem_addr), 32'(v.addr));
            if (iswr && mem_wr) wr_seen = mem_wdata;
            mem_ready = !(c >= 3 && c < 3 + v.nwait);
            mem_rdata = mem_ready ? v.rdata : ~v.rdata;
        end
        mem_ready = 1'b1;
        if (iswr) chkv("mem_model_write", 32'(wr_seen), 32'(v.wdata));
    endtask

    logic [DW-1:0] bb_data[3];
    int k, seen, got;

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk1("rst_mem_rd", mem_rd, 1'b0);
        chk1("rst_mem_wr", mem_wr, 1'b0);
        chkv("rst_mem_addr", 32'(mem_addr), 32'h0);
        chkv("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chkv("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
        chk1("rst_rsp_err", rsp_err, 1'b0);
        chk1("rst_m_start", m_start, 1'b0);
        rst_n = 1'b1;

        vecs[0] = '{op: 2'b01, addr: 16'h0150, wdata: 8'h00, rdata: 8'h3E, nwait: 0};
        vecs[1] = '{op: 2'b10, addr: 16'hC000, wdata: 8'hA5, rdata: 8'h11, nwait: 0};
        vecs[2] = '{op: 2'b00, addr: 16'h1234, wdata: 8'h00, rdata: 8'h22, nwait: 0};
        vecs[3] = '{op: 2'b11, addr: 16'h5678, wdata: 8'h99, rdata: 8'h33, nwait: 2};
        vecs[4] = '{op: 2'b01, addr: 16'h8000, wdata: 8'h00, rdata: 8'h5A, nwait: 3};
        vecs[5] = '{op: 2'b10, addr: 16'hFF80, wdata: 8'h3C, rdata: 8'h44, nwait: 1};
        vecs[6] = '{op: 2'b01, addr: 16'hFFFF, wdata: 8'h00, rdata: 8'h00, nwait: 0};
        for (int i = 0; i < 7; i++) run_txn(vecs[i]);

        // three back-to-back reads with req_valid held
        bb_data[0] = 8'hC1; bb_data[1] = 8'h7E; bb_data[2] = 8'h05;
        k = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b01;
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) @(negedge clk);
            chk1("bb_req_ready", req_ready, (c % 4) == 0);
            chk1("bb_m_start", m_start, (c % 4) == 1);
            chk1("bb_rsp_valid", rsp_valid, c > 0 && (c % 4) == 0);
            if ((c % 4) == 0 && k < 3) begin
                req_addr  = 16'h2000 + 16'(k);
                mem_rdata = bb_data[k];
                exp_q.push_back({1'b0, bb_data[k]});
                last_rd = bb_data[k];
                k++;
            end
            if (c == 9) req_valid = 1'b0;
        end

        // memory stuck not-ready
        @(negedge clk);
        chk1("to_req_ready", req_ready, 1'b1);
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_addr  = 16'h4000;
        mem_rdata = 8'h6C;
        @(posedge clk);
`ifdef SM83_BUS_TIMEOUT_EN
        exp_q.push_back({1'b1, 8'hFF});
        last_rd = 8'hFF;
        for (int c = 1; c <= TPM + MW; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            chk1("to_rsp_valid", rsp_valid, c == TPM + MW);
            chk1("to_mem_rd", mem_rd, c >= 2 && c <= 3 + MW);
            if (c == 3) mem_ready = 1'b0;
        end
        mem_ready = 1'b1;
`else
        exp_q.push_back({1'b0, 8'h6C});
        last_rd = 8'h6C;
        seen = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            if (rsp_valid) seen++;
            if (c == 3) mem_ready = 1'b0;
        end
        chkv("stall_no_rsp", 32'(seen), 32'h0);
        chk1("stall_mem_rd_held", mem_rd, 1'b1);
        mem_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 4 && got == 0; i++) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
        end
        chkv("stall_release_rsp", 32'(got), 32'h1);
`endif

        // reset in phase 2 of a write aborts it
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b10;
        req_addr  = 16'h8001;
        req_wdata = 8'h77;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk1("pre_rst_mem_wr", mem_wr, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("rst_abort_mem_wr", mem_wr, 1'b0);
        chk1("rst_abort_rsp_valid", rsp_valid, 1'b0);
        chkv("rst_abort_mem_addr", 32'(mem_addr), 32'h0);
        chkv("rst_abort_rsp_rdata", 32'(rsp_rdata), 32'h0);
        last_rd = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chkv("rst_no_rsp", 32'(seen), 32'h0);
        chk1("rst_release_ready", req_ready, 1'b1);
        chkv("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
